muldiv_seq_unit: RTL
====================

// Module: muldiv_seq_unit
// PURPOSE
//  Multi-cycle RV32M/RV64M multiply/divide engine. It executes the eight M-extension ops,
//  selected by the 5-bit alufn codes 10000..10111 from the ALU control decode.
//  It sits beside the combinational ALU. The core stalls on busy_o and writes back result_o on valid_o.
//  Generalised over XLEN and bits-retired-per-cycle; adds fast paths for divide-by-zero and overflow.
// PARAMETERS
//  XLEN    32  operand/result width; must be a multiple of UNROLL
//  UNROLL  1   shift-add / restoring-subtract steps per CALC cycle (1,2,4,8)
// PORTS
//  clk       in   1     rising-edge clock
//  rst       in   1     asynchronous active-high reset
//  start_i   in   1     request; accepted only when busy_o=0 and alufn_i[4]=1
//  alufn_i   in   5     10000 MUL,10001 MULH,10010 MULHSU,10011 MULHU,10100 DIV,10101 DIVU,10110 REM,10111 REMU
//  op_a_i    in   XLEN  rs1 operand (multiplicand / dividend)
//  op_b_i    in   XLEN  rs2 operand (multiplier / divisor)
//  flush_i   in   1     abort in-flight op (pipeline flush/trap)
//  busy_o    out  1     1 from the cycle after accept until the cycle valid_o is high (exclusive)
//  valid_o   out  1     single-cycle pulse: result_o is valid
//  result_o  out  XLEN  result; holds its value until the next valid_o
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; busy_o=0, valid_o=0, result_o=0; all internal regs=0.
//  States: IDLE, CALC, FIXUP, DONE.
//   IDLE/DONE + accepted start:
//    - capture op code, operand signs, |a|, |b|.
//    - signed operands: MUL, MULH, DIV, REM (both a and b); MULHSU (a only).
//    - DIV/REM family with b==0, or signed DIV/REM with a==MIN_INT and b==-1:
//      go to DONE (fast path). Otherwise go to CALC and clear the step counter.
//   CALC: perform UNROLL steps per cycle, for XLEN/UNROLL cycles; then go to FIXUP.
//    - mul: 2*XLEN-bit shift-add accumulator on magnitudes.
//    - div: restoring divide on magnitudes; quotient and remainder are XLEN bits.
//   FIXUP (1 cycle): conditionally negate, select the result, then go to DONE.
//    - mul: negate the 2XLEN product if sign_a^sign_b.
//    - div: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
//    - MUL selects the low XLEN bits; MULH/MULHSU/MULHU select the high XLEN bits.
//   DONE: valid_o=1 for exactly this cycle; then IDLE, or a new accept if start_i is high.
//  Latency, accept-edge to valid_o cycle:
//   - normal path: XLEN/UNROLL+2 cycles (34 for XLEN=32, UNROLL=1).
//   - fast path: 1 cycle.
//  Fast-path results:
//   - b==0: DIV/DIVU -> all ones; REM/REMU -> op_a.
//   - overflow: DIV -> MIN_INT (op_a); REM -> 0.
//  Boundaries:
//   - start_i while busy_o=1: ignored; operands are not re-sampled.
//   - start_i with alufn_i[4]=0: ignored; the unit stays IDLE.
//   - start_i in the DONE cycle: accepted back-to-back, no bubble.
//   - flush_i has priority over everything, including start in the same cycle.
//     It forces IDLE next cycle, valid_o stays 0, and result_o keeps its old value.
//   - rst mid-operation: immediate abort to the reset values; no valid_o is issued.
//   - Operands need be stable only in the accept cycle.
//  Arithmetic is two's complement modulo 2^XLEN. Negation of MIN_INT wraps, which is the correct
//  magnitude when treated as unsigned.
// TESTING
//  1. MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> valid_o 34 cycles after accept; result 0xFFFFFFEB.
//  2. MULH/MULHSU/MULHU with a=b=0x80000000 -> 0x40000000, 0xC0000000, 0x40000000 respectively.
//  3. DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; DIVU 20/3 -> 6; REMU 20/3 -> 2.
//  4. DIVU/REMU 0x1234/0 -> valid 1 cycle after accept, 0xFFFFFFFF / 0x1234.
//     DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
//  5. Back-to-back: start held during DONE -> second op accepted with no bubble.
//     start pulsed mid-CALC -> ignored; the first result is unaltered.
//  6. flush_i at CALC cycle 10 -> no valid_o, result_o unchanged.
//     rst asserted mid-CALC -> outputs 0 asynchronously. Repeat 1-4 with UNROLL=4 (latency 10).

Source files
------------

// File: rtl/muldiv_seq_unit.sv
// ---------------------------------------------------------------------------
// muldiv_seq_unit
//   Multi-cycle M-extension multiply/divide engine that sits beside the
//   combinational ALU. Multiplication is a shift-add over operand magnitudes.
//   Division is a restoring divide over operand magnitudes. Signs are applied
//   in a single FIXUP cycle. Divide-by-zero and signed overflow take a
//   one-cycle fast path that skips the iterative datapath.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start_i   request; taken only when idle/done and alufn_i[4]=1
//   alufn_i   5-bit op code: 10000 MUL .. 10111 REMU
//   op_a_i    rs1 (multiplicand / dividend)
//   op_b_i    rs2 (multiplier / divisor)
//   flush_i   abort any in-flight op; beats a same-cycle start
//   busy_o    high while an accepted op is being computed
//   valid_o   one-cycle pulse marking result_o as fresh
//   result_o  last result; held until the next valid_o
// ---------------------------------------------------------------------------
module muldiv_seq_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [4:0]      alufn_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Bit 3 of the op code carries no meaning inside this unit.
    logic unused_alufn;
    assign unused_alufn = alufn_i[3];

    // ---------------- accept-cycle operand conditioning --------------------
    logic            accept;
    logic            in_a_signed, in_b_signed;
    logic            in_sign_a, in_sign_b;
    logic [XLEN-1:0] in_mag_a, in_mag_b;
    logic            in_div_zero, in_ovf;

    assign accept      = start_i && alufn_i[4] &&
                         (state_q == S_IDLE || state_q == S_DONE);
    // mul family: MUL/MULH/MULHSU sign a, MUL/MULH sign b.
    // div family: the even codes (DIV/REM) are signed in both operands.
    assign in_a_signed = alufn_i[2] ? !alufn_i[0] : (alufn_i[1:0] != 2'b11);
    assign in_b_signed = alufn_i[2] ? !alufn_i[0] : !alufn_i[1];
    assign in_sign_a   = in_a_signed & op_a_i[XLEN-1];
    assign in_sign_b   = in_b_signed & op_b_i[XLEN-1];
    // -MIN_INT wraps to MIN_INT, which is the right magnitude read unsigned.
    assign in_mag_a    = in_sign_a ? -op_a_i : op_a_i;
    assign in_mag_b    = in_sign_b ? -op_b_i : op_b_i;
    assign in_div_zero = (op_b_i == '0);
    assign in_ovf      = !alufn_i[0] && (op_a_i == MIN_INT) && (op_b_i == '1);

    // ---------------- iterative datapath ----------------------------------
    // acc holds {hi, lo}. mul: hi = partial product, lo = remaining multiplier
    // bits. div: hi = partial remainder, lo = dividend bits shifting out on the
    // left while quotient bits shift in on the right.
    function automatic logic [2*XLEN-1:0] calc_step(
        input logic [2*XLEN-1:0] acc,
        input logic [XLEN-1:0]   opnd,
        input logic              is_div
    );
        logic [XLEN-1:0] hi, lo, diff;
        logic [XLEN:0]   sum, shifted;
        logic            ge;
        hi      = acc[2*XLEN-1:XLEN];
        lo      = acc[XLEN-1:0];
        sum     = {1'b0, hi} + ({1'b0, opnd} & {(XLEN+1){lo[0]}});
        shifted = {hi, lo[XLEN-1]};
        ge      = (shifted >= {1'b0, opnd});
        // When ge is set the difference is below opnd, so XLEN bits suffice.
        diff    = shifted[XLEN-1:0] - opnd;
        if (is_div)
            calc_step = {(ge ? diff : shifted[XLEN-1:0]), lo[XLEN-2:0], ge};
        else
            calc_step = {sum, lo[XLEN-1:1]};
    endfunction

    logic [2*XLEN-1:0] step_acc;
    always_comb begin
        step_acc = acc_q;
        for (int i = 0; i < UNROLL; i++)
            step_acc = calc_step(step_acc, opnd_q, op_q[2]);
    end

    // ---------------- sign fixup and result select ------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        if (op_q[2])
            fix_result = op_q[1] ? rem_fix : quo_fix;
        else if (op_q[1:0] == 2'b00)
            fix_result = prod_fix[XLEN-1:0];
        else
            fix_result = prod_fix[2*XLEN-1:XLEN];
    end

    // ---------------- next-state logic -------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (accept) begin
                    op_d     = alufn_i[2:0];
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    if (alufn_i[2] && (in_div_zero || in_ovf)) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        if (in_div_zero)
                            result_d = alufn_i[1] ? op_a_i : '1;
                        else
                            result_d = alufn_i[1] ? '0 : op_a_i;
                    end else begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        opnd_d  = alufn_i[2] ? in_mag_b : in_mag_a;
                        acc_d   = {{XLEN{1'b0}}, (alufn_i[2] ? in_mag_a : in_mag_b)};
                    end
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1))
                    state_d = S_FIXUP;
            end
            S_FIXUP: begin
                result_d = fix_result;
                valid_d  = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            valid_d  = 1'b0;
            result_d = result_q;
        end
    end

    // ---------------- state registers --------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule
